frame_buffer_arbiter: RTL and testbench

Sequences and shares the read/write port (port A) of the 256 x 128 x 1-bit frame buffer between two requesters. The first is the microprocessor, which makes single-pixel reads and writes. The second is a built-in rectangle-fill engine that clears or paints regions at one pixel per granted cycle. The block sits between the processor bus adapter and frame buffer port A. The VGA read port (port B) is untouched.

---
 rtl/frame_buffer_pkg.sv | 27 ++
 rtl/frame_buffer_arbiter_if.sv | 26 ++
 rtl/frame_buffer_arbiter_fill_engine.sv | 109 ++++++++++
 rtl/frame_buffer_arbiter.sv | 144 ++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared frame buffer definitions: geometry, address packing and fill states.
// Reused by the arbiter, the frame buffer and the VGA generator.
package frame_buffer_pkg;

  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int ADDR_W = X_W + Y_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_FILL
  } grant_e;

  function automatic logic [ADDR_W-1:0] xy_to_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Request/grant bundle between the fill engine and the port A arbiter.
// The fill engine is the master; the arbiter answers with grant.
interface frame_buffer_arbiter_if #(
  parameter int ADDR_W = frame_buffer_pkg::ADDR_W
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              data;
  logic              grant;

  modport master (
    output req,
    output addr,
    output data,
    input  grant
  );

  modport slave (
    input  req,
    input  addr,
    input  data,
    output grant
  );

endinterface

// File: rtl/frame_buffer_arbiter_fill_engine.sv
// Rectangle fill engine: corner normalisation, x-first cursor and IDLE/FILL/DONE FSM.
// Requests port A while in FILL and advances one pixel per grant.
module fill_engine #(
  parameter int X_W = frame_buffer_pkg::X_W,
  parameter int Y_W = frame_buffer_pkg::Y_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [X_W-1:0]         x0,
  input  logic [X_W-1:0]         x1,
  input  logic [Y_W-1:0]         y0,
  input  logic [Y_W-1:0]         y1,
  input  logic                   colour,
  output logic                   busy,
  output logic                   done,
  frame_buffer_arbiter_if.master bus
);

  import frame_buffer_pkg::*;

  fill_state_e state_q, state_d;

  logic [X_W-1:0] x_q, x_d;
  logic [X_W-1:0] xmin_q, xmin_d;
  logic [X_W-1:0] xmax_q, xmax_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W-1:0] ymax_q, ymax_d;
  logic           colour_q, colour_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    y_d      = y_q;
    ymax_d   = ymax_q;
    colour_d = colour_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          xmin_d   = (x0 < x1) ? x0 : x1;
          xmax_d   = (x0 < x1) ? x1 : x0;
          ymax_d   = (y0 < y1) ? y1 : y0;
          x_d      = xmin_d;
          y_d      = (y0 < y1) ? y0 : y1;
          colour_d = colour;
          state_d  = FILL;
        end
      end
      FILL: begin
        // Compare against the limit so a 0..255 span never wraps early.
        if (bus.grant) begin
          if (x_q == xmax_q) begin
            x_d = xmin_q;
            if (y_q == ymax_q) begin
              state_d = DONE;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      y_q      <= '0;
      ymax_q   <= '0;
      colour_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      y_q      <= y_d;
      ymax_q   <= ymax_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.req  = (state_q == FILL);
  assign bus.addr = {y_q, x_q};
  assign bus.data = colour_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Shares frame buffer port A between CPU single-pixel accesses and the fill engine.
// Round-robin on conflict; CPU reads return two cycles after grant.
module frame_buffer_arbiter #(
  parameter int X_W    = frame_buffer_pkg::X_W,
  parameter int Y_W    = frame_buffer_pkg::Y_W,
  parameter int ADDR_W = X_W + Y_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic              CPU_DATA_IN,
  output logic              CPU_ACK,
  output logic              CPU_DATA_OUT,
  input  logic              FILL_START,
  input  logic [X_W-1:0]    FILL_X0,
  input  logic [X_W-1:0]    FILL_X1,
  input  logic [Y_W-1:0]    FILL_Y0,
  input  logic [Y_W-1:0]    FILL_Y1,
  input  logic              FILL_COLOUR,
  output logic              FILL_BUSY,
  output logic              FILL_DONE,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic              FB_WE,
  output logic              FB_DATA_IN,
  input  logic              FB_DATA_OUT
);

  import frame_buffer_pkg::*;

  frame_buffer_arbiter_if #(.ADDR_W(ADDR_W)) fill_bus ();

  fill_engine #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_fill (
    .clk    (CLK),
    .rst    (RESET),
    .start  (FILL_START),
    .x0     (FILL_X0),
    .x1     (FILL_X1),
    .y0     (FILL_Y0),
    .y1     (FILL_Y1),
    .colour (FILL_COLOUR),
    .busy   (FILL_BUSY),
    .done   (FILL_DONE),
    .bus    (fill_bus.master)
  );

  grant_e            last_q, last_d;
  logic              out_q, out_d;
  logic              p1_q, p1_d;
  logic              p1_rd_q, p1_rd_d;
  logic              p2_q, p2_d;
  logic              p2_rd_q, p2_rd_d;
  logic              ack_q, ack_d;
  logic              dout_q, dout_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              fb_we_q, fb_we_d;
  logic              fb_din_q, fb_din_d;

  logic cpu_elig;
  logic fill_elig;
  logic gnt_cpu;
  logic gnt_fill;

  always_comb begin
    cpu_elig  = CPU_REQ && !out_q;
    fill_elig = fill_bus.req;
    gnt_cpu   = cpu_elig && (!fill_elig || last_q == GNT_FILL);
    gnt_fill  = fill_elig && !gnt_cpu;
  end

  assign fill_bus.grant = gnt_fill;

  always_comb begin
    fb_addr_d = fb_addr_q;
    fb_we_d   = 1'b0;
    fb_din_d  = fb_din_q;
    last_d    = last_q;
    unique case (1'b1)
      gnt_cpu: begin
        fb_addr_d = CPU_ADDR;
        fb_we_d   = CPU_WE;
        fb_din_d  = CPU_DATA_IN;
        last_d    = GNT_CPU;
      end
      gnt_fill: begin
        fb_addr_d = fill_bus.addr;
        fb_we_d   = 1'b1;
        fb_din_d  = fill_bus.data;
        last_d    = GNT_FILL;
      end
      default: ;
    endcase
  end

  // Outstanding stays set through the ACK cycle so a held REQ is not re-granted.
  always_comb begin
    out_d   = gnt_cpu ? 1'b1 : (ack_q ? 1'b0 : out_q);
    p1_d    = gnt_cpu;
    p1_rd_d = gnt_cpu && !CPU_WE;
    p2_d    = p1_q;
    p2_rd_d = p1_rd_q;
    ack_d   = p2_q;
    dout_d  = p2_rd_q ? FB_DATA_OUT : dout_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_q    <= GNT_CPU;
      out_q     <= 1'b0;
      p1_q      <= 1'b0;
      p1_rd_q   <= 1'b0;
      p2_q      <= 1'b0;
      p2_rd_q   <= 1'b0;
      ack_q     <= 1'b0;
      dout_q    <= 1'b0;
      fb_addr_q <= '0;
      fb_we_q   <= 1'b0;
      fb_din_q  <= 1'b0;
    end else begin
      last_q    <= last_d;
      out_q     <= out_d;
      p1_q      <= p1_d;
      p1_rd_q   <= p1_rd_d;
      p2_q      <= p2_d;
      p2_rd_q   <= p2_rd_d;
      ack_q     <= ack_d;
      dout_q    <= dout_d;
      fb_addr_q <= fb_addr_d;
      fb_we_q   <= fb_we_d;
      fb_din_q  <= fb_din_d;
    end
  end

  assign CPU_ACK      = ack_q;
  assign CPU_DATA_OUT = dout_q;
  assign FB_ADDR      = fb_addr_q;
  assign FB_WE        = fb_we_q;
  assign FB_DATA_IN   = fb_din_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a behavioural port A memory.
// Scenario tasks run in sequence and compare against hand-derived values.
module tb_frame_buffer_arbiter;

  import frame_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic        cpu_din;
  logic        cpu_ack;
  logic        cpu_dout;
  logic        fill_start;
  logic [7:0]  fx0, fx1;
  logic [6:0]  fy0, fy1;
  logic        fill_colour;
  logic        fill_busy;
  logic        fill_done;
  logic [14:0] fb_addr;
  logic        fb_we;
  logic        fb_din;
  logic        fb_dout;

  int checks = 0;
  int errors = 0;

  logic        mem  [0:32767];
  logic [7:0]  wcnt [0:32767];
  int          we_count = 0;
  int          cyc_count = 0;
  logic [14:0] wq [$];

  always #5 clk = ~clk;

  frame_buffer_arbiter dut (
    .CLK          (clk),
    .RESET        (rst),
    .CPU_REQ      (cpu_req),
    .CPU_WE       (cpu_we),
    .CPU_ADDR     (cpu_addr),
    .CPU_DATA_IN  (cpu_din),
    .CPU_ACK      (cpu_ack),
    .CPU_DATA_OUT (cpu_dout),
    .FILL_START   (fill_start),
    .FILL_X0      (fx0),
    .FILL_X1      (fx1),
    .FILL_Y0      (fy0),
    .FILL_Y1      (fy1),
    .FILL_COLOUR  (fill_colour),
    .FILL_BUSY    (fill_busy),
    .FILL_DONE    (fill_done),
    .FB_ADDR      (fb_addr),
    .FB_WE        (fb_we),
    .FB_DATA_IN   (fb_din),
    .FB_DATA_OUT  (fb_dout)
  );

  // Port A model: registered read of the old contents, then write.
  always @(posedge clk) begin
    cyc_count++;
    fb_dout <= mem[fb_addr];
    if (fb_we) begin
      mem[fb_addr] = fb_din;
      wcnt[fb_addr] = wcnt[fb_addr] + 8'd1;
      we_count++;
      wq.push_back(fb_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || cpu_dout !== 1'b0) begin
      errors++;
      $display("FAIL reset_cpu: ack=%b dout=%b want 0 0", cpu_ack, cpu_dout);
    end
    checks++;
    if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill: busy=%b done=%b want 0 0", fill_busy, fill_done);
    end
    checks++;
    if (fb_addr !== 15'd0 || fb_we !== 1'b0 || fb_din !== 1'b0) begin
      errors++;
      $display("FAIL reset_fb: addr=%h we=%b din=%b want 0 0 0", fb_addr, fb_we, fb_din);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_rw();
    we_count = 0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 15'h1234;
    cpu_din  = 1'b1;
    tick();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 15'h1234 || fb_din !== 1'b1) begin
      errors++;
      $display("FAIL wr_grant: we=%b addr=%h din=%b want 1 1234 1", fb_we, fb_addr, fb_din);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL wr_mid: ack=%b we=%b want 0 0", cpu_ack, fb_we);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL wr_ack: ack=%b want 1", cpu_ack);
    end
    cpu_req = 1'b0;
    tick();
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack_pulse: ack=%b want 0", cpu_ack);
    end
    cpu_req = 1'b1;
    cpu_we  = 1'b0;
    tick();
    checks++;
    if (fb_we !== 1'b0 || fb_addr !== 15'h1234) begin
      errors++;
      $display("FAIL rd_grant: we=%b addr=%h want 0 1234", fb_we, fb_addr);
    end
    tick();
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_dout !== 1'b1) begin
      errors++;
      $display("FAIL rd_ack: ack=%b dout=%b want 1 1", cpu_ack, cpu_dout);
    end
    cpu_req = 1'b0;
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || cpu_dout !== 1'b1) begin
      errors++;
      $display("FAIL rd_hold: ack=%b dout=%b want 0 1", cpu_ack, cpu_dout);
    end
    cpu_req  = 1'b1;
    cpu_addr = 15'h0001;
    tick();
    tick();
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_dout !== 1'b0) begin
      errors++;
      $display("FAIL rd_zero: ack=%b dout=%b want 1 0", cpu_ack, cpu_dout);
    end
    cpu_req = 1'b0;
    tick();
    checks++;
    if (we_count !== 1) begin
      errors++;
      $display("FAIL cpu_we_pulses: got %0d want 1", we_count);
    end
  endtask

  task automatic test_fill_small(
    input logic [7:0] x0, input logic [6:0] y0,
    input logic [7:0] x1, input logic [6:0] y1,
    input string tag
  );
    logic [14:0] exp_a [6];
    int busy_cycles;
    exp_a[0] = {7'd5, 8'd10};
    exp_a[1] = {7'd5, 8'd11};
    exp_a[2] = {7'd5, 8'd12};
    exp_a[3] = {7'd6, 8'd10};
    exp_a[4] = {7'd6, 8'd11};
    exp_a[5] = {7'd6, 8'd12};
    fx0 = x0; fy0 = y0; fx1 = x1; fy1 = y1;
    fill_colour = 1'b1;
    fill_start  = 1'b1;
    tick();
    fill_start = 1'b0;
    busy_cycles = 0;
    if (fill_busy) busy_cycles++;
    checks++;
    if (fill_busy !== 1'b1 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: busy=%b we=%b want 1 0", tag, fill_busy, fb_we);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fill_busy) busy_cycles++;
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== exp_a[i] || fb_din !== 1'b1 ||
          fill_done !== (i == 5)) begin
        errors++;
        $display("FAIL %s_wr%0d: we=%b addr=%h din=%b done=%b want 1 %h 1 %b",
                 tag, i, fb_we, fb_addr, fb_din, fill_done, exp_a[i], i == 5);
      end
    end
    tick();
    if (fill_busy) busy_cycles++;
    checks++;
    if (fill_busy !== 1'b0 || fill_done !== 1'b0 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: busy=%b done=%b we=%b want 0 0 0",
               tag, fill_busy, fill_done, fb_we);
    end
    checks++;
    if (busy_cycles !== 7) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d want 7", tag, busy_cycles);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    wq.delete();
    fx0 = 8'd0; fy0 = 7'd0; fx1 = 8'd3; fy1 = 7'd0;
    fill_colour = 1'b1;
    fill_start  = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    tick();
    fx0 = 8'd50; fy0 = 7'd50; fx1 = 8'd60; fy1 = 7'd60;
    fill_colour = 1'b0;
    fill_start  = 1'b1;
    tick();
    fill_start = 1'b0;
    n = 0;
    while (fill_busy && n < 20) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_timeout: busy=%b want 0", fill_busy);
    end
    checks++;
    if (wq.size() !== 4) begin
      errors++;
      $display("FAIL restart_count: got %0d writes want 4", wq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wq.size() || wq[i] !== 15'(i)) begin
        errors++;
        $display("FAIL restart_addr%0d: got %h want %h", i,
                 (i < wq.size()) ? wq[i] : 15'h7fff, 15'(i));
      end
    end
    checks++;
    if (mem[15'd3] !== 1'b1) begin
      errors++;
      $display("FAIL restart_colour: got %b want 1", mem[15'd3]);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    fx0 = 8'd20; fy0 = 7'd10; fx1 = 8'd30; fy1 = 7'd20;
    fill_colour = 1'b1;
    fill_start  = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    tick();
    tick();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 15'h0777;
    tick();
    checks++;
    if (fb_we !== 1'b0 || fb_addr !== 15'h0777) begin
      errors++;
      $display("FAIL mid_cpu_grant: we=%b addr=%h want 0 0777", fb_we, fb_addr);
    end
    rst     = 1'b1;
    cpu_req = 1'b0;
    tick();
    checks++;
    if (fb_we !== 1'b0 || fill_busy !== 1'b0 || cpu_ack !== 1'b0 ||
        fill_done !== 1'b0 || fb_addr !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset: we=%b busy=%b ack=%b done=%b addr=%h want 0 0 0 0 0",
               fb_we, fill_busy, cpu_ack, fill_done, fb_addr);
    end
    rst  = 1'b0;
    acks = 0;
    repeat (4) begin
      tick();
      if (cpu_ack) acks++;
    end
    checks++;
    if (acks !== 0 || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: acks=%0d busy=%b want 0 0", acks, fill_busy);
    end
    fx0 = 8'd101; fy0 = 7'd3; fx1 = 8'd100; fy1 = 7'd3;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== {7'd3, 8'd100}) begin
      errors++;
      $display("FAIL fresh_first: we=%b addr=%h want 1 %h", fb_we, fb_addr, {7'd3, 8'd100});
    end
    tick();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== {7'd3, 8'd101} || fill_done !== 1'b1) begin
      errors++;
      $display("FAIL fresh_second: we=%b addr=%h done=%b want 1 %h 1",
               fb_we, fb_addr, fill_done, {7'd3, 8'd101});
    end
    tick();
  endtask

  task automatic test_full_screen();
    int cyc, reads, bad_rd, slow, n, t0, nbad, nnz, base;
    logic [7:0] xr;
    logic       exp_d;
    logic       timed_out;
    for (int x = 0; x < 256; x++) begin
      xr = 8'(x);
      mem[xy_to_addr(xr, 7'd127)] = xr[0] ^ xr[2];
    end
    for (int i = 0; i < 32768; i++) wcnt[i] = 8'd0;
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    base = we_count;
    fx0 = 8'd0; fy0 = 7'd0; fx1 = 8'd255; fy1 = 7'd127;
    fill_colour = 1'b0;
    fill_start  = 1'b1;
    tick();
    t0 = cyc_count;
    fill_start = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    xr       = 8'd0;
    cpu_addr = xy_to_addr(xr, 7'd127);
    tick();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 15'd0) begin
      errors++;
      $display("FAIL conflict_fill_first: we=%b addr=%h want 1 0000", fb_we, fb_addr);
    end
    tick();
    checks++;
    if (fb_we !== 1'b0 || fb_addr !== cpu_addr) begin
      errors++;
      $display("FAIL conflict_cpu_next: we=%b addr=%h want 0 %h", fb_we, fb_addr, cpu_addr);
    end
    cyc = 2;
    reads = 0;
    bad_rd = 0;
    slow = 0;
    timed_out = 1'b0;
    forever begin
      while (!cpu_ack && cyc < 8) begin
        tick();
        cyc++;
      end
      if (!cpu_ack) begin
        timed_out = 1'b1;
        break;
      end
      exp_d = xr[0] ^ xr[2];
      if (cpu_dout !== exp_d) bad_rd++;
      if (cyc > 4) slow++;
      reads++;
      cpu_req = 1'b0;
      tick();
      if (we_count - base >= 30000) break;
      xr       = 8'(reads);
      cpu_addr = xy_to_addr(xr, 7'd127);
      cpu_req  = 1'b1;
      cyc      = 0;
    end
    cpu_req = 1'b0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL full_ack_timeout: no ack within 8 cycles after %0d reads", reads);
    end
    checks++;
    if (bad_rd !== 0 || reads < 5000) begin
      errors++;
      $display("FAIL full_reads: %0d wrong of %0d reads, want 0 wrong and >=5000", bad_rd, reads);
    end
    checks++;
    if (slow !== 0) begin
      errors++;
      $display("FAIL full_cpu_wait: %0d reads took >4 cycles, want 0", slow);
    end
    n = 0;
    while (fill_busy && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (fill_busy !== 1'b0 || cyc_count - t0 > 65540) begin
      errors++;
      $display("FAIL full_duration: busy=%b cycles=%0d want 0 and <=65540",
               fill_busy, cyc_count - t0);
    end
    tick();
    checks++;
    if (we_count - base !== 32768) begin
      errors++;
      $display("FAIL full_writes: got %0d want 32768", we_count - base);
    end
    nbad = 0;
    nnz  = 0;
    for (int i = 0; i < 32768; i++) begin
      if (wcnt[i] !== 8'd1) nbad++;
      if (mem[i] !== 1'b0) nnz++;
    end
    checks++;
    if (nbad !== 0) begin
      errors++;
      $display("FAIL full_once: %0d addresses not written exactly once, want 0", nbad);
    end
    checks++;
    if (nnz !== 0) begin
      errors++;
      $display("FAIL full_colour: %0d pixels nonzero, want 0", nnz);
    end
  endtask

  initial begin
    rst         = 1'b1;
    cpu_req     = 1'b0;
    cpu_we      = 1'b0;
    cpu_addr    = '0;
    cpu_din     = 1'b0;
    fill_start  = 1'b0;
    fx0         = '0;
    fx1         = '0;
    fy0         = '0;
    fy1         = '0;
    fill_colour = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      mem[i]  = 1'b0;
      wcnt[i] = 8'd0;
    end
    test_reset();
    test_cpu_rw();
    test_fill_small(8'd10, 7'd5, 8'd12, 7'd6, "fill_fwd");
    test_fill_small(8'd12, 7'd6, 8'd10, 7'd5, "fill_rev");
    test_start_ignored();
    test_reset_mid();
    test_full_screen();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
